// File: rtl/riscv_defines.sv
// Shared types for the core's pipeline sequencing logic: hazard FSM states and
// the bundled per-stage stall/flush control word.
package riscv_defines;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctrl_t;

  // Canned control words, bit order stall_f..flush_w (MSB first).
  localparam hz_ctrl_t HZ_CTRL_NONE     = hz_ctrl_t'(8'b0000_0000);
  localparam hz_ctrl_t HZ_CTRL_RESET    = hz_ctrl_t'(8'b0000_1111);
  localparam hz_ctrl_t HZ_CTRL_MEM_WAIT = hz_ctrl_t'(8'b1111_0001);
  localparam hz_ctrl_t HZ_CTRL_MD_BUSY  = hz_ctrl_t'(8'b1110_0010);
  localparam hz_ctrl_t HZ_CTRL_REDIRECT = hz_ctrl_t'(8'b0000_1100);
  localparam hz_ctrl_t HZ_CTRL_LOAD_USE = hz_ctrl_t'(8'b1100_0100);

endpackage

// File: rtl/hazard_wait_watchdog.sv
// Counts consecutive data-memory wait cycles and pulses timeout_o on the cycle
// the run reaches WDOG_LIMIT; the count then restarts from zero.
module hazard_wait_watchdog #(
  parameter int unsigned WDOG_W     = 8,
  parameter int unsigned WDOG_LIMIT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_wait_i,
  output logic timeout_o
);

  localparam logic [WDOG_W-1:0] LAST_COUNT = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // cnt_q holds completed wait cycles, so the limit is hit while cnt_q == LIMIT-1.
  always_comb begin
    cnt_d     = '0;
    timeout_o = 1'b0;
    if (!reset && mem_wait_i) begin
      if (cnt_q == LAST_COUNT) begin
        timeout_o = 1'b1;
      end else begin
        cnt_d = cnt_q + WDOG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Per-stage stall/flush sequencing for the 5-stage core: memory waits, mul/div
// handshake, branch redirects and load-use. Define HAZARD_PERF_EN to add counters.
module hazard_stall_controller
  import riscv_defines::*;
#(
  parameter int unsigned WDOG_W     = 8,
  parameter int unsigned WDOG_LIMIT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_e,
  input  logic       memread_e,
  input  logic       pcsrc_e,
  input  logic       md_op_e,
  output logic       md_start,
  input  logic       md_done,
  input  logic       dmem_req_m,
  input  logic       dmem_ack,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       flush_w,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  hz_state_t state_q, state_d;
  logic      done_pend_q, done_pend_d;
  hz_ctrl_t  ctrl;
  logic      mem_wait;
  logic      load_use;
  logic      md_release;

  assign mem_wait   = dmem_req_m && !dmem_ack;
  assign load_use   = memread_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign md_release = (state_q == HZ_MD_WAIT) && (md_done || done_pend_q) && !mem_wait;

  always_comb begin
    ctrl        = HZ_CTRL_NONE;
    md_start    = 1'b0;
    state_d     = state_q;
    done_pend_d = done_pend_q;
    if (reset) begin
      ctrl        = HZ_CTRL_RESET;
      state_d     = HZ_RUN;
      done_pend_d = 1'b0;
    end else if (mem_wait) begin
      ctrl = HZ_CTRL_MEM_WAIT;
      // A completion landing under a memory stall must survive until release.
      if ((state_q == HZ_MD_WAIT) && md_done) begin
        done_pend_d = 1'b1;
      end
    end else if ((state_q == HZ_RUN) && md_op_e) begin
      ctrl     = HZ_CTRL_MD_BUSY;
      md_start = 1'b1;
      state_d  = HZ_MD_WAIT;
    end else if ((state_q == HZ_MD_WAIT) && !md_release) begin
      ctrl = HZ_CTRL_MD_BUSY;
    end else begin
      if (md_release) begin
        state_d     = HZ_RUN;
        done_pend_d = 1'b0;
      end
      // The D instruction is wrong-path on a redirect, so no load-use stall.
      if (pcsrc_e) begin
        ctrl = HZ_CTRL_REDIRECT;
      end else if (load_use) begin
        ctrl = HZ_CTRL_LOAD_USE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HZ_RUN;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign stall_f = ctrl.stall_f;
  assign stall_d = ctrl.stall_d;
  assign stall_e = ctrl.stall_e;
  assign stall_m = ctrl.stall_m;
  assign flush_d = ctrl.flush_d;
  assign flush_e = ctrl.flush_e;
  assign flush_m = ctrl.flush_m;
  assign flush_w = ctrl.flush_w;

  hazard_wait_watchdog #(
    .WDOG_W    (WDOG_W),
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .mem_wait_i(mem_wait),
    .timeout_o (mem_timeout)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl.stall_f) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ctrl.flush_d || ctrl.flush_e) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`endif

endmodule
